apb_completer_regfile: RTL and testbench
========================================

Name: apb_completer_regfile

Overview:
- APB4 completer (slave) backing a small word-addressed register file.
- Responds to PSEL/PENABLE accesses with a programmable number of wait states (PREADY low).
- Flags PSLVERR on out-of-range or misaligned addresses.
- One instance per slave slot on the APB bus, behind the address decoder of the system top; it is the responder end of the master's transfers.

Parameters:
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width; fixed at 32 for PSTRB mapping.
- MEM_DEPTH, 16, number of 32-bit words; power of two, 2..256.
- WAIT_STATES, 0, PREADY-low cycles inserted per access phase, 0..15.
- SLAVE_ID, 0, 8-bit ID placed in the reset pattern.
- BASE_ADDR, 32'h0, slot base; offset = PADDR - BASE_ADDR.

Ports:
- pclk  in  1  bus clock; all logic on rising edge.
- preset  in  1  reset: synchronous, active-high.
- psel  in  1  slot select from decoder.
- penable  in  1  access-phase indicator.
- pwrite  in  1  1=write, 0=read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  4  byte-lane write enables.
- pready  out  1  transfer completion.
- prdata  out  DATA_WIDTH  read data.
- pslverr  out  1  error response.

Behaviour:
- **Reset (preset=1 at edge):**
  - state=IDLE, cnt=0, err_q=0, rdata_q=0.
  - mem[i] = {SLAVE_ID[7:0], 24'(i)}.
  - Outputs: pready=1, prdata=0, pslverr=0.
  - Reset mid-access aborts the transfer with no write commit.
- **FSM states:** IDLE, ACCESS.
- **IDLE:**
  - Setup phase is psel=1, penable=0. At that edge: state→ACCESS, cnt←WAIT_STATES.
  - err_q ← (offset ≥ MEM_DEPTH*4) OR (paddr[1:0]≠0) OR (paddr < BASE_ADDR).
  - rdata_q ← err_q ? 0 : mem[offset>>2].
  - Latch pwrite, word index, pwdata, pstrb.
  - psel=1 with penable=1 seen in IDLE is a protocol error: ignored, stay IDLE.
- **ACCESS:**
  - pready = (cnt==0), combinational from registered cnt.
  - While psel & penable & cnt≠0: cnt decrements by 1 each edge.
  - While psel & penable & pready, at that edge:
    - If write and !err_q: mem[idx] byte lane b ← pwdata_q lane b for each pstrb_q[b]=1.
    - state→IDLE.
  - psel=0 while in ACCESS: abort to IDLE, no commit, no error.
- **Outputs during ACCESS:**
  - prdata = (pready & !pwrite_q & !err_q) ? rdata_q : 0.
  - pslverr = pready & err_q.
  - Both are 0 in IDLE and during wait cycles.
- **Latency:** access phase lasts WAIT_STATES+1 cycles, so total transfer is WAIT_STATES+2 cycles.
- **Back-to-back:** a new setup phase directly after completion is accepted.
  - A read right after a write to the same word returns the new data, because the commit precedes the next setup-edge capture.
- **Error writes:** never modify memory.
- **pstrb=0 write:** completes OKAY with memory unchanged.
- **Ignored inputs:** paddr/pwdata changes during ACCESS are ignored (latched at setup).

Decomposition:
- Shared package apb_pkg:
  - State enum {IDLE, ACCESS}.
  - Localparams STRB_WIDTH=DATA_WIDTH/8 and ADDR_LSB=2.
  - Function init_word(slave_id, idx).
- One sub-module apb_regfile_array:
  - MEM_DEPTH×32 flop array with per-byte write enable and synchronous reset to the init pattern.
  - Combinational read port.
- FSM, wait counter and decode stay in the top.

Test Plan:
- Reset with SLAVE_ID=1, then read offset 0x0 → prdata=32'h01000000, pslverr=0; read 0x4 → 32'h01000001.
- WAIT_STATES=0: write 0x8=32'hDEADBEEF then read 0x8 → pready high the first ACCESS cycle, prdata=32'hDEADBEEF, each transfer exactly 2 cycles.
- WAIT_STATES=2: write 0x0=32'h55555555 → pready low 2 ACCESS cycles, high on 3rd; readback 32'h55555555; memory unchanged before the completing edge.
- Out-of-range read 0x40 (depth 16) and misaligned write 0x2 → pslverr=1 on the completing cycle, prdata=0, memory at 0x0 unchanged.
- pstrb=4'b0101, write 32'hAABBCCDD over 32'h11223344 → readback 32'h11BB33DD; pstrb=0 write → no change, OKAY.
- Abort/reset: drop psel mid-wait (WAIT_STATES=3) → no write, IDLE, pready=1; assert preset mid-ACCESS → all outputs reset values, memory back to the init pattern.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB completer register file.
// Holds the FSM state encoding, lane constants and the reset-pattern generator.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int STRB_WIDTH = 32 / 8;
  localparam int ADDR_LSB   = 2;

  // Reset content of word idx: slave ID in the top byte, word index below.
  function automatic logic [31:0] init_word(input logic [7:0] slave_id,
                                            input int unsigned idx);
    logic [31:0] idx_w;
    idx_w = 32'(idx);
    return {slave_id, idx_w[23:0]};
  endfunction

endpackage

// File: rtl/apb_regfile_array.sv
// Word array with per-byte write enables and a combinational read port.
// Synchronous reset reloads every word with its ID/index pattern.
module apb_regfile_array
  import apb_pkg::*;
#(
  parameter int MEM_DEPTH  = 16,
  parameter int SLAVE_ID   = 0,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      widx_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      ridx_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam logic [7:0] ID8 = 8'(SLAVE_ID);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= init_word(ID8, i);
      end
    end else if (we_i) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb_i[b]) begin
          mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/apb_completer_regfile.sv
// APB4 completer in front of a small register file, with programmable
// wait states and PSLVERR on misaligned, below-base or out-of-range addresses.
module apb_completer_regfile
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 16,
  parameter int                    WAIT_STATES = 0,
  parameter int                    SLAVE_ID    = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_WIDTH-1:0] pstrb,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output state_e                state_o
);

  localparam int                  IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] SPAN  = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);
  localparam logic [3:0]          WS4   = 4'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  addr_err;
  logic [IDX_W-1:0]      ridx;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  we;
  logic                  done;

  // Decode is computed every cycle but only captured at the setup edge.
  assign offset   = paddr - BASE_ADDR;
  assign addr_err = ({1'b0, offset} >= SPAN) || (paddr[1:0] != 2'b00) || (paddr < BASE_ADDR);
  assign ridx     = offset[ADDR_LSB +: IDX_W];
  assign done     = (state_q == ACCESS) && (cnt_q == 4'd0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    pwrite_d = pwrite_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // psel with penable already high in IDLE has no setup phase: ignore it.
        if (psel && !penable) begin
          state_d  = ACCESS;
          cnt_d    = WS4;
          err_d    = addr_err;
          rdata_d  = addr_err ? '0 : mem_rdata;
          pwrite_d = pwrite;
          idx_d    = ridx;
          wdata_d  = pwdata;
          strb_d   = pstrb;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            we      = pwrite_q && !err_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      pwrite_q <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      pwrite_q <= pwrite_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
    end
  end

  apb_regfile_array #(
    .MEM_DEPTH  (MEM_DEPTH),
    .SLAVE_ID   (SLAVE_ID),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i   (pclk),
    .rst_i   (preset),
    .we_i    (we),
    .widx_i  (idx_q),
    .wstrb_i (strb_q),
    .wdata_i (wdata_q),
    .ridx_i  (ridx),
    .rdata_o (mem_rdata)
  );

  assign pready  = (state_q == IDLE) || (cnt_q == 4'd0);
  assign prdata  = (done && !pwrite_q && !err_q) ? rdata_q : '0;
  assign pslverr = done && err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Directed bench for three completer instances: no wait states, two wait
// states, and three wait states behind a non-zero base address.
module tb_apb_completer_regfile;
  import apb_pkg::*;

  logic        pclk;
  logic        preset;
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [31:0] paddr   [3];
  logic [31:0] pwdata  [3];
  logic [3:0]  pstrb   [3];
  logic        pready  [3];
  logic [31:0] prdata  [3];
  logic        pslverr [3];
  state_e      state   [3];

  int n_checks = 0;
  int n_errors = 0;
  int ws_of [3] = '{0, 2, 3};

  apb_completer_regfile #(.WAIT_STATES(0), .SLAVE_ID(8'h01), .BASE_ADDR(32'h0)) u_dut0 (
    .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .pready(pready[0]),
    .prdata(prdata[0]), .pslverr(pslverr[0]), .state_o(state[0]));

  apb_completer_regfile #(.WAIT_STATES(2), .SLAVE_ID(8'h22), .BASE_ADDR(32'h0)) u_dut1 (
    .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .pready(pready[1]),
    .prdata(prdata[1]), .pslverr(pslverr[1]), .state_o(state[1]));

  apb_completer_regfile #(.WAIT_STATES(3), .SLAVE_ID(8'h33), .BASE_ADDR(32'h1000)) u_dut2 (
    .pclk(pclk), .preset(preset), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
    .paddr(paddr[2]), .pwdata(pwdata[2]), .pstrb(pstrb[2]), .pready(pready[2]),
    .prdata(prdata[2]), .pslverr(pslverr[2]), .state_o(state[2]));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the completing edge.
  task automatic apb_xfer(input int k, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic err, output int cycles);
    bit done;
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
    paddr[k] = addr; pwdata[k] = data; pstrb[k] = strb;
    @(posedge pclk); #1;
    penable[k] = 1'b1;
    paddr[k]   = 32'hFFFF_FFF0;
    pwdata[k]  = 32'h0BAD_0BAD;
    cycles = 1;
    done   = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge pclk);
      cycles++;
      if (pready[k]) begin
        done = 1'b1;
      end else begin
        check_eq($sformatf("wait_prdata%0d", k), prdata[k], 32'h0);
        check_eq($sformatf("wait_pslverr%0d", k), {31'h0, pslverr[k]}, 32'h0);
        @(posedge pclk); #1;
      end
    end
    if (!done) check_eq($sformatf("timeout%0d", k), 32'h0, 32'h1);
    rdata = prdata[k];
    err   = pslverr[k];
    @(posedge pclk); #1;
    psel[k] = 1'b0; penable[k] = 1'b0;
  endtask

  task automatic rd(input int k, input logic [31:0] addr, input logic [31:0] exp_data,
                    input logic exp_err);
    logic [31:0] d; logic e; int c;
    apb_xfer(k, 1'b0, addr, 32'h0, 4'h0, d, e, c);
    check_eq($sformatf("rd%0d_%h_data", k, addr), d, exp_data);
    check_eq($sformatf("rd%0d_%h_err", k, addr), {31'h0, e}, {31'h0, exp_err});
    check_eq($sformatf("rd%0d_%h_cycles", k, addr), 32'(c), 32'(ws_of[k] + 2));
  endtask

  task automatic wr(input int k, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic exp_err);
    logic [31:0] d; logic e; int c;
    apb_xfer(k, 1'b1, addr, data, strb, d, e, c);
    check_eq($sformatf("wr%0d_%h_prdata", k, addr), d, 32'h0);
    check_eq($sformatf("wr%0d_%h_err", k, addr), {31'h0, e}, {31'h0, exp_err});
    check_eq($sformatf("wr%0d_%h_cycles", k, addr), 32'(c), 32'(ws_of[k] + 2));
  endtask

  task automatic check_idle(input int k, input string tag);
    check_eq({tag, "_state"},   {31'h0, state[k]},   {31'h0, IDLE});
    check_eq({tag, "_pready"},  {31'h0, pready[k]},  32'h1);
    check_eq({tag, "_prdata"},  prdata[k],           32'h0);
    check_eq({tag, "_pslverr"}, {31'h0, pslverr[k]}, 32'h0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
      paddr[k] = '0; pwdata[k] = '0; pstrb[k] = '0;
    end
    preset = 1'b1;
    @(posedge pclk); @(negedge pclk);
    for (int k = 0; k < 3; k++) check_idle(k, $sformatf("reset%0d", k));
    @(posedge pclk); #1;
    preset = 1'b0;

    // Reset pattern, boundary words, zero-wait write/readback back-to-back.
    rd(0, 32'h0,  32'h0100_0000, 1'b0);
    rd(0, 32'h4,  32'h0100_0001, 1'b0);
    rd(0, 32'h3C, 32'h0100_000F, 1'b0);
    wr(0, 32'h8,  32'hDEAD_BEEF, 4'hF, 1'b0);
    rd(0, 32'h8,  32'hDEAD_BEEF, 1'b0);

    // Error responses never touch memory; 0x40 aliases word 0 if undecoded.
    rd(0, 32'h40, 32'h0, 1'b1);
    wr(0, 32'h2,  32'hCAFE_F00D, 4'hF, 1'b1);
    wr(0, 32'h40, 32'hCAFE_F00D, 4'hF, 1'b1);
    rd(0, 32'h0,  32'h0100_0000, 1'b0);

    // Byte strobes and an empty-strobe write.
    wr(0, 32'hC, 32'h1122_3344, 4'hF, 1'b0);
    wr(0, 32'hC, 32'hAABB_CCDD, 4'b0101, 1'b0);
    rd(0, 32'hC, 32'h11BB_33DD, 1'b0);
    wr(0, 32'hC, 32'hFFFF_FFFF, 4'h0, 1'b0);
    rd(0, 32'hC, 32'h11BB_33DD, 1'b0);

    // Setup phase skipped: psel and penable together in IDLE are ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
    paddr[0] = 32'h0; pwdata[0] = 32'h1234_5678; pstrb[0] = 4'hF;
    @(posedge pclk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge pclk);
    check_idle(0, "proto_err");
    @(posedge pclk); #1;
    rd(0, 32'h0, 32'h0100_0000, 1'b0);

    // Two wait states.
    rd(1, 32'h0, 32'h2200_0000, 1'b0);
    wr(1, 32'h0, 32'h5555_5555, 4'hF, 1'b0);
    rd(1, 32'h0, 32'h5555_5555, 1'b0);

    // Three wait states behind base 0x1000, including the below-base boundary.
    rd(2, 32'h1004, 32'h3300_0001, 1'b0);
    rd(2, 32'h0FFC, 32'h0, 1'b1);
    rd(2, 32'h1040, 32'h0, 1'b1);
    rd(2, 32'h103C, 32'h3300_000F, 1'b0);

    // Drop psel in the middle of the wait: nothing is written.
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
    paddr[2] = 32'h1004; pwdata[2] = 32'h1234_5678; pstrb[2] = 4'hF;
    @(posedge pclk); #1;
    penable[2] = 1'b1;
    @(posedge pclk); #1;
    psel[2] = 1'b0; penable[2] = 1'b0;
    @(posedge pclk); @(negedge pclk);
    check_idle(2, "abort");
    @(posedge pclk); #1;
    rd(2, 32'h1004, 32'h3300_0001, 1'b0);

    // Reset in the middle of an access restores outputs and memory contents.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h4; pwdata[1] = 32'hAAAA_AAAA; pstrb[1] = 4'hF;
    @(posedge pclk); #1;
    penable[1] = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); @(negedge pclk);
    check_idle(1, "mid_reset");
    @(posedge pclk); #1;
    preset = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    rd(1, 32'h0, 32'h2200_0000, 1'b0);
    rd(1, 32'h4, 32'h2200_0001, 1'b0);
    rd(0, 32'h8, 32'h0100_0002, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
